current_search_ctrl: RTL and testbench
======================================

// Module: current_search_ctrl
// PURPOSE
// Closed-loop current-reference search controller. It drives i_ref into the analog front-end
// and reads back q_measured after a programmable settle time. It iterates until
// |q_measured - q_desired| <= TOL. Two run-time modes: bisection (0) and false-position (1).
// Assumes q rises monotonically with i_ref. Reports status, iteration count and the best i_ref found.
// PARAMETERS
// BUS_WIDTH      10  width of i_ref, q_desired, q_measured, i_ref_setup
// TOL            1   convergence tolerance on |q_measured - q_desired| (LSB)
// SETTLE_CYCLES  2   clocks between an i_ref update and the q_measured sample (>=1)
// MAX_ITER       16  max interior probes before abort (>=1)
// ITER_W         5   width of iter_count; must hold MAX_ITER
// PORTS
// clk          in   1          clock, rising edge
// rst_n        in   1          asynchronous active-low reset
// start        in   1          one-cycle request; ignored while busy=1
// mode         in   1          0 bisection, 1 false-position; sampled at start
// q_desired    in   BUS_WIDTH  target Q; sampled at start
// i_ref_setup  in   BUS_WIDTH  upper search bound; sampled at start (lower bound is 0)
// q_measured   in   BUS_WIDTH  plant readback
// i_ref        out  BUS_WIDTH  current reference to plant
// busy         out  1          search in progress
// done         out  1          high from search end until next accepted start
// status       out  2          00 converged, 01 out_of_range, 10 iter_limit, 11 bracket_collapse
// iter_count   out  ITER_W     interior probes evaluated in this/last search
// BEHAVIOUR
// - Reset (async, any state): i_ref=0, busy=0, done=0, status=00, iter_count=0, FSM=IDLE.
//   A search in progress is abandoned without a done pulse.
// - Error: err = q_measured - q_desired, signed BUS_WIDTH+1 bits. "hit" = |err| <= TOL.
// - Probe: i_ref <= x; wait SETTLE_CYCLES clocks (SETTLE); sample q_measured (EVAL).
//   Track best = the probe with the smallest |err|; ties keep the earlier probe.
// - FSM: IDLE -> PROBE_LO(x=0) -> PROBE_HI(x=i_ref_setup) -> STEP -> [DIV] -> SETTLE -> EVAL
//   -> STEP | DONE. Accepted start sets busy=1, done=0, iter_count=0 next cycle.
// - Endpoints: if either endpoint hits, go to DONE with 00. If f(lo) > TOL or f(hi) < -TOL,
//   go to DONE with 01. Endpoint probes do not count in iter_count.
//   If i_ref_setup == 0, only PROBE_LO runs.
// - STEP, bisection: c = (a+b)>>1 with a BUS_WIDTH+1 sum. SETTLE follows next cycle.
// - STEP, false-position: c = a + ((-fa)*(b-a)) / (fb-fa). The product is unsigned 2*BUS_WIDTH+1.
//   The divider is sequential restoring, exactly BUS_WIDTH+1 cycles in DIV, floor result.
//   If c==a or c==b, use the bisection midpoint instead.
// - EVAL: iter_count++. If hit, DONE 00. Else if err<0 then a=c, fa=err; else b=c, fb=err.
//   Then check in order: b-a <= 1 -> DONE 11; iter_count == MAX_ITER -> DONE 10; else STEP.
// - DONE: i_ref = best probe's x (held); busy=0, done=1; status and iter_count held.
//   Returns to IDLE same cycle; outputs stay until next accepted start.
// - start asserted while busy: no effect. start on the same cycle as rst_n low: reset wins.
// - q_measured is only sampled in EVAL; changes at other times are ignored.
// TESTING
// Plant model for all tests: q = i_ref>>2, delayed SETTLE_CYCLES; i_ref_setup=1023.
// Bisection, q_desired=110: probes 511,255,383,447 -> i_ref=447, status 00, iter_count=4.
// False-position, q_desired=110: one DIV, probe 441 -> i_ref=441, status 00, iter_count=1.
// q_desired=300 (above max 255): no interior probes -> i_ref=1023, status 01, iter_count=0.
// MAX_ITER=2, bisection, q_desired=110: probes 511,255 -> i_ref=511 (|err|=17), status 10.
// TOL=0, plant q=(i_ref>>3)<<1, q_desired=111 -> status 11, i_ref=best-|err| probe.
// rst_n low mid-SETTLE -> outputs zero same cycle. start while busy ignored. Restart runs clean.

Source files
------------

// File: rtl/current_search_if.sv
// Handshake/bus bundle between the current-search controller and its host/plant.
// The slave side is the controller; the master side drives requests and the plant readback.
interface current_search_if #(
   parameter int BUS_WIDTH = 10,
   parameter int ITER_W    = 5
);
   logic                 start;
   logic                 mode;
   logic [BUS_WIDTH-1:0] q_desired;
   logic [BUS_WIDTH-1:0] i_ref_setup;
   logic [BUS_WIDTH-1:0] q_measured;
   logic [BUS_WIDTH-1:0] i_ref;
   logic                 busy;
   logic                 done;
   logic [1:0]           status;
   logic [ITER_W-1:0]    iter_count;

   modport master (
      output start, mode, q_desired, i_ref_setup, q_measured,
      input  i_ref, busy, done, status, iter_count
   );

   modport slave (
      input  start, mode, q_desired, i_ref_setup, q_measured,
      output i_ref, busy, done, status, iter_count
   );
endinterface

// File: rtl/current_search_ctrl.sv
// Closed-loop i_ref search: bisection or false-position over [0, i_ref_setup]
// until |q_measured - q_desired| <= TOL, reporting the best probe seen.
module current_search_ctrl #(
   parameter int BUS_WIDTH     = 10,
   parameter int TOL           = 1,
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_ITER      = 16,
   parameter int ITER_W        = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   current_search_if.slave bus
);
   localparam int W   = BUS_WIDTH;
   localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int DCW = $clog2(W + 1);
   localparam logic [W:0] TOL_V = (W+1)'(TOL);
   localparam logic [1:0] ST_CONV = 2'b00, ST_OOR = 2'b01, ST_ITER = 2'b10, ST_COLL = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_PROBE_LO, S_PROBE_HI, S_STEP, S_DIV, S_SETTLE, S_EVAL, S_DONE} state_t;
   typedef enum logic [1:0] {PH_LO, PH_HI, PH_MID} phase_t;

   state_t              state_q, state_d, eval_next;
   phase_t              phase_q, phase_d;
   logic                mode_q, mode_d;
   logic [W-1:0]        q_des_q, q_des_d, hi_q, hi_d, a_q, a_d, b_q, b_d;
   logic signed [W:0]   fa_q, fa_d, fb_q, fb_d;
   logic [W-1:0]        best_x_q, best_x_d;
   logic [W:0]          best_abs_q, best_abs_d;
   logic [W-1:0]        i_ref_q, i_ref_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic [1:0]          status_q, status_d, eval_status;
   logic [ITER_W-1:0]   iter_q, iter_d, iter_inc;
   logic [SCW-1:0]      cnt_q, cnt_d;
   logic [DCW-1:0]      div_cnt_q, div_cnt_d;
   logic [W:0]          rem_q, rem_d, num_q, num_d, den_q, den_d;
   logic [W-1:0]        quo_q, quo_d;

   logic signed [W:0]   err;
   logic                err_neg, hit, better, eval_fin, start_ok, div_last, settle_last, div_ge, fp_degen;
   logic [W:0]          abs_err, best_abs_new, sum_ab, neg_fa, den_val, div_rem_next, quo_next, fp_c;
   logic [W-1:0]        best_x_new, a_new, b_new, mid, span_ab;
   logic [2*W:0]        prod;
   logic [W+1:0]        div_shift;

   assign err          = $signed({1'b0, bus.q_measured}) - $signed({1'b0, q_des_q});
   assign err_neg      = err[W];
   assign abs_err      = err_neg ? -err : err;
   assign hit          = (abs_err <= TOL_V);
   assign better       = (abs_err < best_abs_q);
   assign best_x_new   = better ? i_ref_q : best_x_q;
   assign best_abs_new = better ? abs_err : best_abs_q;
   assign a_new        = (phase_q == PH_MID && err_neg)  ? i_ref_q : a_q;
   assign b_new        = (phase_q == PH_MID && !err_neg) ? i_ref_q : b_q;
   assign iter_inc     = iter_q + ITER_W'(1);
   assign start_ok     = bus.start && (state_q == S_IDLE || state_q == S_DONE);
   assign settle_last  = (cnt_q == SCW'(SETTLE_CYCLES - 1));

   assign sum_ab  = {1'b0, a_q} + {1'b0, b_q};
   assign mid     = W'(sum_ab >> 1);
   assign neg_fa  = -fa_q;
   assign span_ab = b_q - a_q;
   assign prod    = (2*W+1)'(neg_fa) * (2*W+1)'(span_ab);
   assign den_val = fb_q - fa_q;

   // The quotient never exceeds b-a, so the top dividend bits start as the
   // partial remainder and only W+1 restoring steps are needed.
   assign div_shift    = {rem_q, num_q[W]};
   assign div_ge       = (div_shift >= {1'b0, den_q});
   assign div_rem_next = div_ge ? (W+1)'(div_shift - {1'b0, den_q}) : div_shift[W:0];
   assign quo_next     = {quo_q, div_ge};
   assign div_last     = (div_cnt_q == DCW'(W));
   assign fp_c         = {1'b0, a_q} + quo_next;
   assign fp_degen     = (quo_next == '0) || (fp_c == {1'b0, b_q});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;    phase_q <= PH_LO;    mode_q <= 1'b0;
         q_des_q <= '0;        hi_q <= '0;          a_q <= '0;        b_q <= '0;
         fa_q <= '0;           fb_q <= '0;          best_x_q <= '0;   best_abs_q <= '1;
         i_ref_q <= '0;        busy_q <= 1'b0;      done_q <= 1'b0;   status_q <= ST_CONV;
         iter_q <= '0;         cnt_q <= '0;         div_cnt_q <= '0;
         rem_q <= '0;          num_q <= '0;         den_q <= '0;      quo_q <= '0;
      end else begin
         state_q <= state_d;   phase_q <= phase_d;  mode_q <= mode_d;
         q_des_q <= q_des_d;   hi_q <= hi_d;        a_q <= a_d;       b_q <= b_d;
         fa_q <= fa_d;         fb_q <= fb_d;        best_x_q <= best_x_d; best_abs_q <= best_abs_d;
         i_ref_q <= i_ref_d;   busy_q <= busy_d;    done_q <= done_d; status_q <= status_d;
         iter_q <= iter_d;     cnt_q <= cnt_d;      div_cnt_q <= div_cnt_d;
         rem_q <= rem_d;       num_q <= num_d;      den_q <= den_d;   quo_q <= quo_d;
      end
   end

   // Decide the outcome of the probe sampled this cycle.
   always_comb begin
      eval_fin    = 1'b0;
      eval_status = ST_CONV;
      eval_next   = S_STEP;
      case (phase_q)
         PH_LO: begin
            if (hit) eval_fin = 1'b1;
            else if (!err_neg || hi_q == '0) begin eval_fin = 1'b1; eval_status = ST_OOR; end
            else eval_next = S_PROBE_HI;
         end
         PH_HI: begin
            if (hit) eval_fin = 1'b1;
            else if (err_neg) begin eval_fin = 1'b1; eval_status = ST_OOR; end
         end
         default: begin
            if (hit) eval_fin = 1'b1;
            else if (b_new - a_new <= W'(1)) begin eval_fin = 1'b1; eval_status = ST_COLL; end
            else if (iter_inc == ITER_W'(MAX_ITER)) begin eval_fin = 1'b1; eval_status = ST_ITER; end
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: state_d = start_ok ? S_PROBE_LO : S_IDLE;
         S_PROBE_LO:     state_d = S_SETTLE;
         S_PROBE_HI:     state_d = S_SETTLE;
         S_STEP:         state_d = mode_q ? S_DIV : S_SETTLE;
         S_DIV:          state_d = div_last ? S_SETTLE : S_DIV;
         S_SETTLE:       state_d = settle_last ? S_EVAL : S_SETTLE;
         S_EVAL:         state_d = eval_fin ? S_DONE : eval_next;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      phase_d = phase_q;   mode_d = mode_q;     q_des_d = q_des_q;   hi_d = hi_q;
      a_d = a_q;           b_d = b_q;           fa_d = fa_q;         fb_d = fb_q;
      best_x_d = best_x_q; best_abs_d = best_abs_q;
      i_ref_d = i_ref_q;   busy_d = busy_q;     done_d = done_q;     status_d = status_q;
      iter_d = iter_q;     cnt_d = cnt_q;       div_cnt_d = div_cnt_q;
      rem_d = rem_q;       num_d = num_q;       den_d = den_q;       quo_d = quo_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_ok) begin
               busy_d = 1'b1;  done_d = 1'b0;  iter_d = '0;
               mode_d = bus.mode;  q_des_d = bus.q_desired;  hi_d = bus.i_ref_setup;
               best_x_d = '0;  best_abs_d = '1;
            end
         end
         S_PROBE_LO: begin i_ref_d = '0;   phase_d = PH_LO; cnt_d = '0; end
         S_PROBE_HI: begin i_ref_d = hi_q; phase_d = PH_HI; cnt_d = '0; end
         S_STEP: begin
            if (mode_q) begin
               rem_d = {1'b0, prod[2*W:W+1]};  num_d = prod[W:0];
               den_d = den_val;  quo_d = '0;  div_cnt_d = '0;
            end else begin
               i_ref_d = mid;  phase_d = PH_MID;  cnt_d = '0;
            end
         end
         S_DIV: begin
            rem_d = div_rem_next;  num_d = {num_q[W-1:0], 1'b0};
            quo_d = quo_next[W-1:0];  div_cnt_d = div_cnt_q + DCW'(1);
            if (div_last) begin
               i_ref_d = fp_degen ? mid : fp_c[W-1:0];
               phase_d = PH_MID;  cnt_d = '0;
            end
         end
         S_SETTLE: cnt_d = cnt_q + SCW'(1);
         S_EVAL: begin
            best_x_d = best_x_new;  best_abs_d = best_abs_new;
            case (phase_q)
               PH_LO: begin a_d = '0;   fa_d = err; end
               PH_HI: begin b_d = hi_q; fb_d = err; end
               default: begin
                  a_d = a_new;  b_d = b_new;  iter_d = iter_inc;
                  if (err_neg) fa_d = err;
                  else         fb_d = err;
               end
            endcase
            if (eval_fin) begin
               i_ref_d = best_x_new;  busy_d = 1'b0;  done_d = 1'b1;  status_d = eval_status;
            end
         end
         default: ;
      endcase
   end

   assign bus.i_ref      = i_ref_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.status     = status_q;
   assign bus.iter_count = iter_q;
endmodule

// File: tb/tb_current_search_ctrl.sv
// Directed bench: three controller instances (default, MAX_ITER=2, TOL=0) each
// closed around a delayed plant model, checked against hand-computed results.
module tb_current_search_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_a, start_b, start_c, mode;
   logic [9:0] q_des, setup;
   int         checks = 0;
   int         errors = 0;

   current_search_if #(.BUS_WIDTH(10), .ITER_W(5)) bus_a ();
   current_search_if #(.BUS_WIDTH(10), .ITER_W(5)) bus_b ();
   current_search_if #(.BUS_WIDTH(10), .ITER_W(5)) bus_c ();

   assign bus_a.start = start_a;  assign bus_b.start = start_b;  assign bus_c.start = start_c;
   assign bus_a.mode = mode;      assign bus_b.mode = mode;      assign bus_c.mode = mode;
   assign bus_a.q_desired = q_des;   assign bus_b.q_desired = q_des;   assign bus_c.q_desired = q_des;
   assign bus_a.i_ref_setup = setup; assign bus_b.i_ref_setup = setup; assign bus_c.i_ref_setup = setup;

   // Plants: q follows i_ref after two clocks.
   logic [9:0] pa1, pa2, pb1, pb2, pc1, pc2;
   always @(posedge clk) begin
      pa1 <= bus_a.i_ref;  pa2 <= pa1;
      pb1 <= bus_b.i_ref;  pb2 <= pb1;
      pc1 <= bus_c.i_ref;  pc2 <= pc1;
   end
   assign bus_a.q_measured = pa2 >> 2;
   assign bus_b.q_measured = pb2 >> 2;
   assign bus_c.q_measured = (pc2 >> 3) << 1;

   current_search_ctrl u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   current_search_ctrl #(.MAX_ITER(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
   current_search_ctrl #(.TOL(0)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic get_out(input int sel, output logic [9:0] ir, output logic bz, output logic dn,
                          output logic [1:0] st, output logic [4:0] it);
      case (sel)
         0: begin ir = bus_a.i_ref; bz = bus_a.busy; dn = bus_a.done; st = bus_a.status; it = bus_a.iter_count; end
         1: begin ir = bus_b.i_ref; bz = bus_b.busy; dn = bus_b.done; st = bus_b.status; it = bus_b.iter_count; end
         default: begin ir = bus_c.i_ref; bz = bus_c.busy; dn = bus_c.done; st = bus_c.status; it = bus_c.iter_count; end
      endcase
   endtask

   task automatic pulse_start(input int sel, input logic m, input logic [9:0] qd);
      @(negedge clk);
      mode = m;  q_des = qd;
      case (sel)
         0: start_a = 1'b1;
         1: start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      @(negedge clk);
      start_a = 1'b0;  start_b = 1'b0;  start_c = 1'b0;
   endtask

   task automatic wait_done(input int sel, output int cyc);
      logic [9:0] ir; logic bz, dn; logic [1:0] st; logic [4:0] it;
      cyc = 0;
      get_out(sel, ir, bz, dn, st, it);
      while (!dn && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         get_out(sel, ir, bz, dn, st, it);
      end
      chk("done_seen", {31'd0, dn}, 32'd1);
   endtask

   task automatic report_check(input int sel, input string name, input int cyc,
                               input int exp_iref, input int exp_st, input int exp_it);
      logic [9:0] ir; logic bz, dn; logic [1:0] st; logic [4:0] it;
      get_out(sel, ir, bz, dn, st, it);
      $display("%s dut=%0d mode=%0d q_des=%0d i_ref=%0d status=%0d iter=%0d cycles=%0d",
               name, sel, mode, q_des, ir, st, it, cyc);
      chk({name, "_iref"}, {22'd0, ir}, exp_iref);
      chk({name, "_status"}, {30'd0, st}, exp_st);
      chk({name, "_iter"}, {27'd0, it}, exp_it);
      chk({name, "_busy"}, {31'd0, bz}, 32'd0);
   endtask

   task automatic run_check(input int sel, input logic m, input logic [9:0] qd, input string name,
                            input int exp_iref, input int exp_st, input int exp_it);
      int cyc;
      pulse_start(sel, m, qd);
      wait_done(sel, cyc);
      report_check(sel, name, cyc, exp_iref, exp_st, exp_it);
   endtask

   initial begin
      logic [9:0] ir; logic bz, dn; logic [1:0] st; logic [4:0] it;
      int cyc;
      rst_n = 1'b0;  start_a = 1'b0;  start_b = 1'b0;  start_c = 1'b0;
      mode = 1'b0;   q_des = '0;      setup = 10'd1023;
      repeat (3) @(negedge clk);
      get_out(0, ir, bz, dn, st, it);
      $display("reset i_ref=%0d busy=%0d done=%0d status=%0d iter=%0d", ir, bz, dn, st, it);
      chk("reset_iref", {22'd0, ir}, 0);
      chk("reset_busy", {31'd0, bz}, 0);
      chk("reset_done", {31'd0, dn}, 0);
      chk("reset_status", {30'd0, st}, 0);
      chk("reset_iter", {27'd0, it}, 0);
      rst_n = 1'b1;

      run_check(0, 1'b0, 10'd110, "bisect", 447, 0, 4);
      run_check(0, 1'b1, 10'd110, "falsepos", 441, 0, 1);
      run_check(0, 1'b0, 10'd300, "oor", 1023, 1, 0);
      run_check(1, 1'b0, 10'd110, "iterlim", 511, 2, 2);
      run_check(2, 1'b0, 10'd111, "collapse", 447, 3, 10);

      // A second start while busy must not disturb the running bisection.
      pulse_start(0, 1'b0, 10'd110);
      repeat (4) @(negedge clk);
      pulse_start(0, 1'b1, 10'd300);
      wait_done(0, cyc);
      report_check(0, "busy_ign", cyc, 447, 0, 4);

      // Reset in the middle of the upper-endpoint settle.
      pulse_start(0, 1'b0, 10'd110);
      repeat (5) @(negedge clk);
      get_out(0, ir, bz, dn, st, it);
      chk("mid_busy", {31'd0, bz}, 1);
      chk("mid_iref", {22'd0, ir}, 1023);
      rst_n = 1'b0;
      #1;
      get_out(0, ir, bz, dn, st, it);
      $display("midreset i_ref=%0d busy=%0d done=%0d status=%0d iter=%0d", ir, bz, dn, st, it);
      chk("mrst_iref", {22'd0, ir}, 0);
      chk("mrst_busy", {31'd0, bz}, 0);
      chk("mrst_done", {31'd0, dn}, 0);
      chk("mrst_status", {30'd0, st}, 0);
      chk("mrst_iter", {27'd0, it}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_check(0, 1'b0, 10'd110, "restart", 447, 0, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
